// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// MEM stage of the 5-stage MIPS pipeline, between the EX/MEM register and
// writeback. It drives a ready-handshake data-memory bus for word and byte
// loads and stores. Byte loads are sign-extended. The stage stalls the
// pipeline while the bus inserts wait states, and it aborts an access that
// stays unanswered for MAX_WAIT cycles. It traps misaligned word accesses,
// resolves branch/jump redirect, and holds the registered MEM/WB boundary.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   alu_result_in            effective address / ALU result
//   reg_file_out_2_in        store data
//   register_destination_in  writeback register
//   zero_flag_in, jump_in, branch_in, branch_target_in   redirect inputs
//   memory_read_in, memory_write_in                       load/store request
//   memory_read_source_in    0 = word load, 1 = byte load
//   memory_write_source_in   0 = word store, 1 = byte store
//   memory_to_register_in, reg_write_in                   writeback control
//   dmem_req/we/addr/wdata/be (out), dmem_rdata/ready (in) data bus
//   stall_out                freeze PC, IF/ID, ID/EX, EX/MEM
//   pc_src_out, branch_target_out   redirect
//   read_data_out, alu_result_out, register_destination_out,
//   memory_to_register_out, reg_write_out                 MEM/WB register
//   misaligned_out, bus_error_out   one-cycle trap pulses
module mem_access_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] reg_file_out_2_in,
    input  logic [4:0]  register_destination_in,
    input  logic        zero_flag_in,
    input  logic [31:0] branch_target_in,
    input  logic        jump_in,
    input  logic        branch_in,
    input  logic        memory_read_in,
    input  logic        memory_write_in,
    input  logic        memory_read_source_in,
    input  logic        memory_write_source_in,
    input  logic        memory_to_register_in,
    input  logic        reg_write_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall_out,
    output logic        pc_src_out,
    output logic [31:0] branch_target_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  register_destination_out,
    output logic        memory_to_register_out,
    output logic        reg_write_out,
    output logic        misaligned_out,
    output logic        bus_error_out
);

    localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state, state_next;
    logic [7:0]  wcnt, wcnt_next;
    logic        access;
    logic        is_load;
    logic        word_access;
    logic        misaligned;
    logic        timeout;
    logic        retire_ok;
    logic [7:0]  load_byte;
    logic [31:0] load_data;

    // When both read and write are requested, only the write happens. The
    // write source therefore decides the access width in that case.
    assign access      = memory_read_in | memory_write_in;
    assign is_load     = memory_read_in & ~memory_write_in;
    assign word_access = memory_write_in ? ~memory_write_source_in : ~memory_read_source_in;
    assign misaligned  = (state == S_IDLE) & access & word_access &
                         (alu_result_in[1:0] != 2'b00);
    assign retire_ok   = ~misaligned & ~timeout;

    assign dmem_we           = memory_write_in;
    assign dmem_addr         = {alu_result_in[31:2], 2'b00};
    assign pc_src_out        = jump_in | (branch_in & zero_flag_in);
    assign branch_target_out = branch_target_in;

    // Store lane steering. A byte store replicates its byte on all lanes and
    // enables only the addressed lane (little-endian). Everything else uses
    // all four lanes.
    always_comb begin
        dmem_wdata = reg_file_out_2_in;
        dmem_be    = 4'b1111;
        if (memory_write_in & memory_write_source_in) begin
            dmem_wdata = {4{reg_file_out_2_in[7:0]}};
            dmem_be    = 4'b0001 << alu_result_in[1:0];
        end
    end

    // Load lane selection. The byte is picked by the low address bits and is
    // sign-extended.
    always_comb begin
        case (alu_result_in[1:0])
            2'd0:    load_byte = dmem_rdata[7:0];
            2'd1:    load_byte = dmem_rdata[15:8];
            2'd2:    load_byte = dmem_rdata[23:16];
            default: load_byte = dmem_rdata[31:24];
        endcase
        load_data = memory_read_source_in ? {{24{load_byte[7]}}, load_byte} : dmem_rdata;
    end

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            wcnt  <= 8'd0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    // Next-state logic. A request that is not answered in its first cycle
    // enters WAIT with the counter at 1. The state then leaves WAIT when the
    // bus answers or when the timeout fires.
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        case (state)
            S_IDLE: begin
                if (dmem_req & ~dmem_ready) begin
                    state_next = S_WAIT;
                    wcnt_next  = 8'd1;
                end
            end
            default: begin
                if (dmem_ready | timeout) begin
                    state_next = S_IDLE;
                    wcnt_next  = 8'd0;
                end else begin
                    wcnt_next = wcnt + 8'd1;
                end
            end
        endcase
    end

    // Bus request and stall. Reset wins combinationally, so an access that is
    // interrupted by reset releases the bus and the pipeline in that same
    // cycle. In the timeout cycle the request is still up, but the pipeline
    // is released so that the instruction retires without effect.
    always_comb begin
        dmem_req  = 1'b0;
        stall_out = 1'b0;
        timeout   = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    dmem_req  = access & ~misaligned;
                    stall_out = access & ~misaligned & ~dmem_ready;
                end
                default: begin
                    dmem_req  = 1'b1;
                    timeout   = ~dmem_ready & (wcnt == MAX_WAIT_CNT);
                    stall_out = ~dmem_ready & ~(wcnt == MAX_WAIT_CNT);
                end
            endcase
        end
    end

    // MEM/WB boundary. A stalled cycle inserts a bubble: the write-enables
    // drop and the data fields hold. A trapped or timed-out instruction
    // passes through with its write-enables and load data cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_out            <= 32'd0;
            alu_result_out           <= 32'd0;
            register_destination_out <= 5'd0;
            memory_to_register_out   <= 1'b0;
            reg_write_out            <= 1'b0;
            misaligned_out           <= 1'b0;
            bus_error_out            <= 1'b0;
        end else if (stall_out) begin
            memory_to_register_out   <= 1'b0;
            reg_write_out            <= 1'b0;
            misaligned_out           <= 1'b0;
            bus_error_out            <= 1'b0;
        end else begin
            read_data_out            <= (is_load & retire_ok) ? load_data : 32'd0;
            alu_result_out           <= alu_result_in;
            register_destination_out <= register_destination_in;
            memory_to_register_out   <= memory_to_register_in & retire_ok;
            reg_write_out            <= reg_write_in & retire_ok;
            misaligned_out           <= misaligned;
            bus_error_out            <= timeout;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage, built with MAX_WAIT = 4.
// Zero-wait transactions come from a vector table. Wait-state, timeout and
// reset-mid-access behaviour is driven by hand-written sequences. Expected
// MEM/WB contents are queued when an instruction is driven, and they are
// compared on each edge where the stage is not stalled.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result_in, reg_file_out_2_in, branch_target_in, dmem_rdata;
    logic [4:0]  register_destination_in;
    logic        zero_flag_in, jump_in, branch_in, memory_read_in, memory_write_in;
    logic        memory_read_source_in, memory_write_source_in;
    logic        memory_to_register_in, reg_write_in, dmem_ready;
    logic        dmem_req, dmem_we, stall_out, pc_src_out;
    logic [31:0] dmem_addr, dmem_wdata, branch_target_out, read_data_out, alu_result_out;
    logic [3:0]  dmem_be;
    logic [4:0]  register_destination_out;
    logic        memory_to_register_out, reg_write_out, misaligned_out, bus_error_out;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic rd, wr, rsrc, wsrc, jump, branch, zero, ready, regw, m2r;
        logic [4:0]  rdst;
        logic [31:0] addr, sdata, rdata;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_read;
        logic        exp_rwo, exp_m2r, exp_mis, exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] read_data, alu;
        logic [4:0]  rdst;
        logic        rwo, m2r, mis, berr;
    } wb_t;

    wb_t  sb[$];
    vec_t vecs[$];

    mem_access_stage #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .alu_result_in(alu_result_in), .reg_file_out_2_in(reg_file_out_2_in),
        .register_destination_in(register_destination_in), .zero_flag_in(zero_flag_in),
        .branch_target_in(branch_target_in), .jump_in(jump_in), .branch_in(branch_in),
        .memory_read_in(memory_read_in), .memory_write_in(memory_write_in),
        .memory_read_source_in(memory_read_source_in),
        .memory_write_source_in(memory_write_source_in),
        .memory_to_register_in(memory_to_register_in), .reg_write_in(reg_write_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .stall_out(stall_out), .pc_src_out(pc_src_out),
        .branch_target_out(branch_target_out), .read_data_out(read_data_out),
        .alu_result_out(alu_result_out), .register_destination_out(register_destination_out),
        .memory_to_register_out(memory_to_register_out), .reg_write_out(reg_write_out),
        .misaligned_out(misaligned_out), .bus_error_out(bus_error_out)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so that the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Argument order: rd wr rsrc wsrc jump branch zero ready regw m2r rdst addr sdata rdata
    //                 exp_req exp_be exp_wdata exp_read exp_rwo exp_m2r exp_mis exp_pc
    function automatic vec_t mkVec(input logic rd, wr, rsrc, wsrc, jump, branch, zero,
                                   ready, regw, m2r, input logic [4:0] rdst,
                                   input logic [31:0] addr, sdata, rdata,
                                   input logic exp_req, input logic [3:0] exp_be,
                                   input logic [31:0] exp_wdata, exp_read,
                                   input logic exp_rwo, exp_m2r, exp_mis, exp_pc);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rsrc = rsrc; v.wsrc = wsrc; v.jump = jump;
        v.branch = branch; v.zero = zero; v.ready = ready; v.regw = regw; v.m2r = m2r;
        v.rdst = rdst; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.exp_req = exp_req; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        v.exp_read = exp_read; v.exp_rwo = exp_rwo; v.exp_m2r = exp_m2r;
        v.exp_mis = exp_mis; v.exp_pc = exp_pc;
        return v;
    endfunction

    function automatic wb_t expectFrom(input vec_t v);
        wb_t w;
        w.read_data = v.exp_read; w.alu = v.addr; w.rdst = v.rdst;
        w.rwo = v.exp_rwo; w.m2r = v.exp_m2r; w.mis = v.exp_mis; w.berr = 1'b0;
        return w;
    endfunction

    task automatic applyStimulus(input vec_t v);
        memory_read_in = v.rd; memory_write_in = v.wr;
        memory_read_source_in = v.rsrc; memory_write_source_in = v.wsrc;
        jump_in = v.jump; branch_in = v.branch; zero_flag_in = v.zero;
        dmem_ready = v.ready; reg_write_in = v.regw; memory_to_register_in = v.m2r;
        register_destination_in = v.rdst; alu_result_in = v.addr;
        reg_file_out_2_in = v.sdata; dmem_rdata = v.rdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic compareWb(input string tag, input wb_t e);
        checkOutput({tag, "_read_data"}, read_data_out, e.read_data);
        checkOutput({tag, "_alu_result"}, alu_result_out, e.alu);
        checkOutput({tag, "_rd"}, 32'(register_destination_out), 32'(e.rdst));
        checkOutput({tag, "_reg_write"}, 32'(reg_write_out), 32'(e.rwo));
        checkOutput({tag, "_mem_to_reg"}, 32'(memory_to_register_out), 32'(e.m2r));
        checkOutput({tag, "_misaligned"}, 32'(misaligned_out), 32'(e.mis));
        checkOutput({tag, "_bus_error"}, 32'(bus_error_out), 32'(e.berr));
    endtask

    task automatic checkAllZero(input string tag);
        wb_t z;
        z.read_data = '0; z.alu = '0; z.rdst = '0;
        z.rwo = 1'b0; z.m2r = 1'b0; z.mis = 1'b0; z.berr = 1'b0;
        compareWb(tag, z);
    endtask

    // Called at a negedge. This task advances to just after the next posedge
    // and then retires the oldest queued expectation if that edge was not
    // stalled. A reset edge flushes the queue.
    task automatic stepCycle(input string tag);
        logic wasStall, wasRst;
        wb_t  e;
        wasStall = stall_out;
        wasRst   = rst;
        @(posedge clk);
        #1;
        if (wasRst) begin
            sb.delete();
        end else if (!wasStall) begin
            if (sb.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL %s_scoreboard: got output, expected none queued", tag);
            end else begin
                e = sb.pop_front();
                compareWb(tag, e);
            end
        end
    endtask

    initial begin
        vec_t nop, v;
        wb_t  w;
        int   stallCount;
        bit   done;

        nop = mkVec(0,0,0,0, 0,0,0, 0, 0,0, 5'd0, 32'h0, 32'h0, 32'h0,
                    0, 4'hF, 32'h0, 32'h0, 0,0,0,0);

        // Zero-wait and no-request cases.
        vecs.push_back(mkVec(1,0,0,0, 0,0,0, 1, 1,1, 5'd5, 32'h10, 32'h0, 32'hDEADBEEF,
                             1, 4'hF, 32'h0, 32'hDEADBEEF, 1,1,0,0));
        vecs.push_back(mkVec(1,0,1,0, 0,0,0, 1, 1,1, 5'd7, 32'h21, 32'h0, 32'h123480FF,
                             1, 4'hF, 32'h0, 32'hFFFFFF80, 1,1,0,0));
        vecs.push_back(mkVec(1,0,1,0, 0,0,0, 1, 1,1, 5'd7, 32'h21, 32'h0, 32'h00007F00,
                             1, 4'hF, 32'h0, 32'h0000007F, 1,1,0,0));
        vecs.push_back(mkVec(1,0,1,0, 0,0,0, 1, 1,1, 5'd8, 32'h22, 32'h0, 32'h00AB0000,
                             1, 4'hF, 32'h0, 32'hFFFFFFAB, 1,1,0,0));
        vecs.push_back(mkVec(1,0,1,0, 0,0,0, 1, 1,1, 5'd9, 32'h23, 32'h0, 32'hC0112233,
                             1, 4'hF, 32'h0, 32'hFFFFFFC0, 1,1,0,0));
        vecs.push_back(mkVec(0,1,0,0, 0,0,0, 1, 0,0, 5'd1, 32'h40, 32'h11223344, 32'h0,
                             1, 4'hF, 32'h11223344, 32'h0, 0,0,0,0));
        vecs.push_back(mkVec(0,1,0,1, 0,0,0, 1, 0,0, 5'd2, 32'h12, 32'h1234565A, 32'h0,
                             1, 4'b0100, 32'h5A5A5A5A, 32'h0, 0,0,0,0));
        vecs.push_back(mkVec(1,0,0,0, 0,0,0, 0, 1,1, 5'd4, 32'h06, 32'h0, 32'h99999999,
                             0, 4'hF, 32'h0, 32'h0, 0,0,1,0));
        vecs.push_back(mkVec(0,1,0,0, 0,0,0, 0, 0,0, 5'd6, 32'h03, 32'hCAFEF00D, 32'h0,
                             0, 4'hF, 32'hCAFEF00D, 32'h0, 0,0,1,0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,0, 0, 1,0, 5'd10, 32'h1234, 32'h0, 32'h0,
                             0, 4'hF, 32'h0, 32'h0, 1,0,0,1));
        vecs.push_back(mkVec(1,1,0,1, 0,0,0, 1, 0,0, 5'd11, 32'h41, 32'h00000077, 32'hFFFFFFFF,
                             1, 4'b0010, 32'h77777777, 32'h0, 0,0,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,1,0, 0, 1,0, 5'd3, 32'hFFFFFFFC, 32'h0, 32'h0,
                             0, 4'hF, 32'h0, 32'h0, 1,0,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,1,1, 0, 1,0, 5'd12, 32'h88, 32'h0, 32'h0,
                             0, 4'hF, 32'h0, 32'h0, 1,0,0,1));
        vecs.push_back(mkVec(1,0,1,0, 0,0,0, 1, 1,1, 5'd13, 32'h06, 32'h0, 32'h00420000,
                             1, 4'hF, 32'h0, 32'h00000042, 1,1,0,0));

        // Reset with a pending word load on the inputs. The request and the
        // stall must stay low, and every registered output must be cleared.
        branch_target_in = 32'h0;
        applyStimulus(nop);
        memory_read_in = 1'b1;
        alu_result_in  = 32'h10;
        reg_write_in   = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        checkOutput("reset_req", 32'(dmem_req), 32'd0);
        checkOutput("reset_stall", 32'(stall_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven single-cycle transactions.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v);
            sb.push_back(expectFrom(v));
            @(negedge clk);
            checkOutput($sformatf("v%0d_req", i), 32'(dmem_req), 32'(v.exp_req));
            checkOutput($sformatf("v%0d_we", i), 32'(dmem_we), 32'(v.wr));
            checkOutput($sformatf("v%0d_be", i), 32'(dmem_be), 32'(v.exp_be));
            checkOutput($sformatf("v%0d_addr", i), dmem_addr, {v.addr[31:2], 2'b00});
            checkOutput($sformatf("v%0d_stall", i), 32'(stall_out), 32'd0);
            checkOutput($sformatf("v%0d_pc_src", i), 32'(pc_src_out), 32'(v.exp_pc));
            if (v.wr)
                checkOutput($sformatf("v%0d_wdata", i), dmem_wdata, v.exp_wdata);
            stepCycle($sformatf("v%0d", i));
        end

        // Byte store to lane 3 that completes after three wait cycles.
        v = mkVec(0,1,0,1, 0,0,0, 0, 0,0, 5'd14, 32'h13, 32'h000000A5, 32'h0,
                  1, 4'b1000, 32'hA5A5A5A5, 32'h0, 0,0,0,0);
        applyStimulus(v);
        sb.push_back(expectFrom(v));
        stallCount = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            dmem_ready = (k >= 3);
            @(negedge clk);
            checkOutput("bstore_be", 32'(dmem_be), 32'b1000);
            checkOutput("bstore_wdata", dmem_wdata, 32'hA5A5A5A5);
            checkOutput("bstore_we", 32'(dmem_we), 32'd1);
            checkOutput("bstore_req", 32'(dmem_req), 32'd1);
            if (stall_out) begin
                stallCount++;
                if (k >= 1)
                    checkOutput("bstore_bubble_rwo", 32'(reg_write_out), 32'd0);
            end
            done = !stall_out;
            stepCycle("bstore");
        end
        checkOutput("bstore_done", 32'(done), 32'd1);
        checkOutput("bstore_stall_cycles", 32'(stallCount), 32'd3);

        // Timeout: with MAX_WAIT = 4 and no ready, the stall covers cycles
        // 0..3, cycle 4 aborts, and the instruction retires with bus_error.
        v = mkVec(1,0,0,0, 0,0,0, 0, 1,1, 5'd9, 32'h100, 32'h0, 32'h0,
                  1, 4'hF, 32'h0, 32'h0, 0,0,0,0);
        applyStimulus(v);
        w = expectFrom(v);
        w.berr = 1'b1;
        sb.push_back(w);
        stallCount = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            checkOutput($sformatf("tmo_stall_c%0d", k), 32'(stall_out), 32'(k < 4));
            checkOutput($sformatf("tmo_req_c%0d", k), 32'(dmem_req), 32'd1);
            if (stall_out)
                stallCount++;
            done = !stall_out;
            stepCycle("tmo");
        end
        checkOutput("tmo_done", 32'(done), 32'd1);
        checkOutput("tmo_stall_cycles", 32'(stallCount), 32'd4);
        applyStimulus(nop);
        sb.push_back(expectFrom(nop));
        @(negedge clk);
        checkOutput("tmo_req_dropped", 32'(dmem_req), 32'd0);
        stepCycle("tmo_after");
        v = mkVec(1,0,0,0, 0,0,0, 1, 1,1, 5'd9, 32'h104, 32'h0, 32'h00000055,
                  1, 4'hF, 32'h0, 32'h00000055, 1,1,0,0);
        applyStimulus(v);
        sb.push_back(expectFrom(v));
        @(negedge clk);
        checkOutput("tmo_idle_stall", 32'(stall_out), 32'd0);
        stepCycle("tmo_reload");

        // Reset during the second WAIT cycle. The redirect stays combinational
        // throughout.
        v = mkVec(1,0,0,0, 0,0,0, 0, 1,1, 5'd17, 32'h200, 32'h0, 32'h0,
                  1, 4'hF, 32'h0, 32'h0, 1,1,0,0);
        applyStimulus(v);
        sb.push_back(expectFrom(v));
        @(negedge clk);
        checkOutput("rstw_stall_c0", 32'(stall_out), 32'd1);
        stepCycle("rstw_c0");
        branch_in = 1'b1;
        zero_flag_in = 1'b1;
        branch_target_in = 32'h00401000;
        @(negedge clk);
        checkOutput("rstw_stall_c1", 32'(stall_out), 32'd1);
        checkOutput("rstw_pc_src_stalled", 32'(pc_src_out), 32'd1);
        stepCycle("rstw_c1");
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstw_req", 32'(dmem_req), 32'd0);
        checkOutput("rstw_stall", 32'(stall_out), 32'd0);
        checkOutput("rstw_pc_src", 32'(pc_src_out), 32'd1);
        checkOutput("rstw_branch_target", branch_target_out, 32'h00401000);
        stepCycle("rstw_c2");
        checkAllZero("rstw_regs");
        rst = 1'b0;
        applyStimulus(nop);
        branch_target_in = 32'h0;
        sb.push_back(expectFrom(nop));
        @(negedge clk);
        checkOutput("rstw_idle_req", 32'(dmem_req), 32'd0);
        stepCycle("rstw_nop");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM pipeline register and writeback.
- Drives a ready-handshake data-memory bus for word and byte loads and stores. Loads are sign-extended. Stalls the pipeline on wait states.
- Aborts a hung access on timeout, traps misaligned word accesses, and resolves branch/jump redirect.
- Contains the registered MEM/WB boundary.

Parameters:
MAX_WAIT, 16, wait cycles tolerated after the request cycle before a bus timeout; legal range 1..255.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alu_result_in  in  32  effective address / ALU result
reg_file_out_2_in  in  32  store data
register_destination_in  in  5  writeback register
zero_flag_in  in  1  ALU zero
branch_target_in  in  32  branch/jump target
jump_in, branch_in  in  1  control
memory_read_in, memory_write_in  in  1  load/store request
memory_read_source_in  in  1  0 = word load, 1 = byte load (sign-extended)
memory_write_source_in  in  1  0 = word store, 1 = byte store
memory_to_register_in, reg_write_in  in  1  writeback control
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_addr  out  32  word-aligned address ({alu_result_in[31:2],2'b00})
dmem_wdata  out  32  write data
dmem_be  out  4  byte enables
dmem_rdata  in  32  read data
dmem_ready  in  1  access complete this cycle
stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
pc_src_out  out  1  redirect PC
branch_target_out  out  32  pass-through of branch_target_in
read_data_out  out  32  MEM/WB: load data
alu_result_out  out  32  MEM/WB: ALU result
register_destination_out  out  5  MEM/WB
memory_to_register_out, reg_write_out  out  1  MEM/WB
misaligned_out  out  1  one-cycle registered trap pulse
bus_error_out  out  1  one-cycle registered timeout pulse

Behaviour:
- Reset is synchronous and active-high.
  - It clears every registered output to 0, state to IDLE, and the wait counter to 0.
  - It forces dmem_req = 0 and stall_out = 0 combinationally in the reset cycle, which also covers reset mid-access.
- The access signal is memory_read_in | memory_write_in.
  - If both are set, the block performs a write only.
  - dmem_we = memory_write_in.
- misaligned is asserted when an access is a word access and alu_result_in[1:0] != 0.
  - No request is issued and no stall occurs.
  - On the next edge: misaligned_out = 1 and reg_write_out = 0.
- The FSM has two states, IDLE and WAIT. A wait counter, wcnt, is 8 bits wide.
  - IDLE: dmem_req = access & ~misaligned.
    - If dmem_req & dmem_ready, this is a zero-wait completion. The MEM/WB register captures the result and there is no stall.
    - If dmem_req & ~dmem_ready, stall_out = 1, the state moves to WAIT, and wcnt is set to 1.
  - WAIT: dmem_req = 1 and stall_out = ~dmem_ready. The EX/MEM inputs are held stable upstream.
    - On dmem_ready: the MEM/WB register captures the result and the state moves to IDLE.
    - Else, if wcnt == MAX_WAIT: dmem_req drops in the following cycle and the state moves to IDLE.
      - In that timeout cycle, stall_out = 0, bus_error_out is set to 1 at the next edge, and reg_write_out is set to 0.
      - The instruction retires without effect.
    - Else wcnt is incremented.
- While stall_out = 1, MEM/WB captures a bubble: reg_write_out = 0, memory_to_register_out = 0, and the data fields hold.
- Store data and byte enables:
  - Word store: dmem_wdata = store data, dmem_be = 4'b1111.
  - Byte store: dmem_wdata = {4{store[7:0]}}, dmem_be = 4'b0001 << alu_result_in[1:0] (little-endian).
  - Reads drive dmem_be = 4'b1111.
- Load data:
  - Word load: read_data_out = dmem_rdata.
  - Byte load: the lane is selected by alu_result_in[1:0] and sign-extended to 32 bits.
- Non-memory instructions pass to MEM/WB on every non-stalled edge. read_data_out is 0 for non-loads.
- pc_src_out = jump_in | (branch_in & zero_flag_in). It is combinational and independent of stall.
- misaligned_out and bus_error_out are single-cycle pulses and cleared on the following edge.

Test Plan:
1. Word load, addr 0x0000_0010, ready same cycle, rdata 0xDEAD_BEEF, reg_write=1, rd=5 -> stall_out never 1. Next edge: read_data_out = 0xDEADBEEF, register_destination_out = 5, reg_write_out = 1.
2. Byte store, addr 0x0000_0013, data 0x0000_00A5, ready after 3 cycles -> dmem_be = 4'b1000, dmem_wdata = 0xA5A5A5A5, dmem_we = 1. stall_out high for exactly 3 cycles; reg_write_out = 0 during the stall.
3. Byte load, addr 0x0000_0021, rdata 0x1234_80FF -> read_data_out = 0xFFFF_FF80. Same with rdata 0x0000_7F00 -> 0x0000_007F.
4. Word load, addr 0x0000_0006 -> dmem_req stays 0, no stall. misaligned_out = 1 for one cycle and reg_write_out = 0.
5. MAX_WAIT = 4, dmem_ready held 0 -> stall for cycles 0..3, then the request drops. bus_error_out pulses once, reg_write_out = 0, and the FSM returns to IDLE.
6. rst asserted during the second WAIT cycle -> dmem_req = 0 and stall_out = 0 in that cycle. All registered outputs are 0 next edge. branch_in = 1, zero_flag_in = 1 -> pc_src_out = 1 and branch_target_out equals the input.
